// File: rtl/dac_sweep_ctrl.sv
// Phase-increment sweep controller for the CORDIC DAC: steps phase_inc from start to stop with a dwell per value.
// Optional build macro SWEEP_BIDIR_EN turns looping sweeps into triangle sweeps instead of sawtooth.
module dac_sweep_ctrl #(
    parameter int unsigned PW = 19,
    parameter int unsigned DW = 16
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic [PW-1:0] cfg_start_inc,
    input  logic [PW-1:0] cfg_stop_inc,
    input  logic [PW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_loop,
    input  logic          start,
    input  logic          abort,
    output logic [PW-1:0] phase_inc,
    output logic          busy,
    output logic          done,
    output logic          step_strobe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] start_sh_q, start_sh_d;
    logic [PW-1:0] stop_sh_q, stop_sh_d;
    logic [PW-1:0] step_sh_q, step_sh_d;
    logic [DW-1:0] dwell_sh_q, dwell_sh_d;
    logic          loop_sh_q, loop_sh_d;
    logic          dir_up_q, dir_up_d;
    logic          done_q, done_d;
    logic          strobe_q, strobe_d;
    logic          at_stop;

    // One step toward target, evaluated one bit wider so neither direction can wrap past the endpoint.
    function automatic logic [PW-1:0] step_toward(
        input logic [PW-1:0] cur,
        input logic [PW-1:0] step,
        input logic [PW-1:0] target,
        input logic          up
    );
        logic [PW:0] sum;
        logic [PW:0] diff;
        logic [PW-1:0] res;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (up) begin
            res = (sum >= {1'b0, target}) ? target : sum[PW-1:0];
        end else begin
            res = (diff[PW] || (diff[PW-1:0] <= target)) ? target : diff[PW-1:0];
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] dwell_reload(input logic [DW-1:0] d);
        return (d == '0) ? '0 : d - DW'(1);
    endfunction

    assign at_stop = (phase_q == stop_sh_q);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            cnt_q      <= '0;
            start_sh_q <= '0;
            stop_sh_q  <= '0;
            step_sh_q  <= '0;
            dwell_sh_q <= '0;
            loop_sh_q  <= 1'b0;
            dir_up_q   <= 1'b1;
            done_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            start_sh_q <= start_sh_d;
            stop_sh_q  <= stop_sh_d;
            step_sh_q  <= step_sh_d;
            dwell_sh_q <= dwell_sh_d;
            loop_sh_q  <= loop_sh_d;
            dir_up_q   <= dir_up_d;
            done_q     <= done_d;
            strobe_q   <= strobe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = DWELL;
                DWELL:   if (cnt_q == '0) state_d = STEP;
                STEP:    state_d = (at_stop && !loop_sh_q) ? IDLE : DWELL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        start_sh_d = start_sh_q;
        stop_sh_d  = stop_sh_q;
        step_sh_d  = step_sh_q;
        dwell_sh_d = dwell_sh_q;
        loop_sh_d  = loop_sh_q;
        dir_up_d   = dir_up_q;
        done_d     = 1'b0;
        strobe_d   = 1'b0;
        if (!abort) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        start_sh_d = cfg_start_inc;
                        stop_sh_d  = cfg_stop_inc;
                        step_sh_d  = cfg_step;
                        dwell_sh_d = cfg_dwell;
                        loop_sh_d  = cfg_loop;
                        dir_up_d   = (cfg_start_inc <= cfg_stop_inc);
                        phase_d    = cfg_start_inc;
                        cnt_d      = dwell_reload(cfg_dwell);
                        strobe_d   = 1'b1;
                    end
                end
                DWELL: begin
                    if (cnt_q != '0) cnt_d = cnt_q - DW'(1);
                end
                STEP: begin
                    if (at_stop && !loop_sh_q) begin
                        done_d = 1'b1;
                    end else if (at_stop) begin
`ifdef SWEEP_BIDIR_EN
                        // Turn around at the endpoint and take the first step back in this same STEP.
                        start_sh_d = stop_sh_q;
                        stop_sh_d  = start_sh_q;
                        dir_up_d   = !dir_up_q;
                        phase_d    = step_toward(phase_q, step_sh_q, start_sh_q, !dir_up_q);
`else
                        phase_d    = start_sh_q;
`endif
                        cnt_d      = dwell_reload(dwell_sh_q);
                        strobe_d   = 1'b1;
                    end else begin
                        phase_d  = step_toward(phase_q, step_sh_q, stop_sh_q, dir_up_q);
                        cnt_d    = dwell_reload(dwell_sh_q);
                        strobe_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        phase_inc   = phase_q;
        done        = done_q;
        step_strobe = strobe_q;
    end

endmodule
